// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared encodings and code constants for the combination lock and its key sender
//
// Contents:
//   LOCK_CODE_LEN / LOCK_CODE : default unlock code, sent MSB first
//   lock_state_t              : 3-bit lock FSM state encoding (progress through the code)
//   sender_state_t            : key sender FSM states
package lock_pkg;

    localparam int                         LOCK_CODE_LEN = 6;
    localparam logic [LOCK_CODE_LEN-1:0]   LOCK_CODE     = 6'b101011;

    // s_got<k bits> values count the number of correct bits received so far,
    // so s_got10101 + 1 is s_open.
    typedef enum logic [2:0] {
        s_reset,
        s_got1,
        s_got10,
        s_got101,
        s_got1010,
        s_got10101,
        s_open,
        s_error
    } lock_state_t;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_READY,
        SEND,
        CONFIRM,
        HOLD,
        RELEASE,
        RECOVER,
        DONE_OK,
        FAIL
    } sender_state_t;

endpackage

// File: rtl/lock_sender_timer.sv
// rtl/lock_sender_timer.sv - clearable saturating up-counter with compare output
//
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : synchronous clear, wins over counting
//   limit   : compare value for hit
//   hit     : count == limit
module lock_sender_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != {WIDTH{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/lock_key_sender.sv
// rtl/lock_key_sender.sv - serial initiator that unlocks, holds and releases the combination lock
//
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : one-cycle request to run an unlock sequence (ignored while busy)
//   ready    : lock ready output
//   unlock   : lock unlock output
//   error    : lock error output
//   x        : registered serial bit to the lock
//   busy     : high from start accept until done
//   done     : one-cycle pulse at sequence end
//   success  : valid with done, 1 = unlocked and released
//   attempts : attempts used in the current/last run
module lock_key_sender
    import lock_pkg::*;
#(
    parameter int                    CODE_LEN    = LOCK_CODE_LEN,
    parameter logic [CODE_LEN-1:0]   CODE        = LOCK_CODE,
    parameter int                    HOLD_CYCLES = 4,
    parameter int                    TIMEOUT     = 16,
    parameter int                    MAX_RETRY   = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       ready,
    input  logic       unlock,
    input  logic       error,
    output logic       x,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic [1:0] attempts
);

    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    // The shared timer must also reach HOLD_CYCLES-1, so size it for the larger limit.
    localparam int TW = $clog2(((TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES) + 1);

    localparam logic [IW-1:0] IDX_MSB   = IW'(CODE_LEN - 1);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_HOLD    = TW'(HOLD_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    sender_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    att_d;
    logic          x_d, busy_d, done_d, success_d;
    logic          timer_hit;
    logic [TW-1:0] timer_limit;
    logic          timer_clear;

    // One timer covers both the per-state timeout and the HOLD length; every
    // state change restarts it from zero.
    assign timer_clear = (state_d != state_q);
    assign timer_limit = (state_q == HOLD) ? T_HOLD : T_TIMEOUT;

    lock_sender_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .hit     (timer_hit)
    );

    // State and registered outputs. x must come straight from a flop because
    // the lock's outputs depend combinationally on x.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            attempts <= '0;
            x        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            success  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            attempts <= att_d;
            x        <= x_d;
            busy     <= busy_d;
            done     <= done_d;
            success  <= success_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        att_d   = attempts;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_READY;
                    att_d   = 2'd1;
                end
            end
            WAIT_READY: begin
                if (ready) begin
                    state_d = SEND;
                    idx_d   = IDX_MSB;
                end else if (timer_hit) begin
                    state_d = FAIL;
                end
            end
            SEND: begin
                if (error) begin
                    state_d = RECOVER;
                end else if (idx_q == '0) begin
                    state_d = CONFIRM;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            CONFIRM: begin
                // error outranks unlock when both appear together
                if (error) begin
                    state_d = RECOVER;
                end else if (unlock) begin
                    state_d = HOLD;
                end else if (timer_hit) begin
                    state_d = FAIL;
                end
            end
            HOLD: begin
                if (timer_hit) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (ready) begin
                    state_d = DONE_OK;
                end else if (timer_hit) begin
                    state_d = FAIL;
                end
            end
            RECOVER: begin
                if (ready) begin
                    if (attempts <= RETRY_MAX) begin
                        state_d = SEND;
                        idx_d   = IDX_MSB;
                        att_d   = attempts + 2'd1;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (timer_hit) begin
                    state_d = FAIL;
                end
            end
            DONE_OK: state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear on the same edge
    // as the transition (e.g. the MSB leaves together with entry to SEND).
    always_comb begin
        x_d       = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        success_d = 1'b0;
        case (state_d)
            SEND:    x_d = CODE[idx_d];
            CONFIRM: x_d = 1'b1;
            HOLD:    x_d = 1'b1;
            IDLE:    busy_d = 1'b0;
            DONE_OK: begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                success_d = 1'b1;
            end
            FAIL: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lock_key_sender.sv
// tb/tb_lock_key_sender.sv - scoreboard bench for lock_key_sender against a behavioural lock
module tb_lock_key_sender;
    import lock_pkg::*;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       ready, unlock, error;
    logic       x, busy, done, success;
    logic [1:0] attempts;

    always #5 clock = ~clock;

    lock_key_sender dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .ready    (ready),
        .unlock   (unlock),
        .error    (error),
        .x        (x),
        .busy     (busy),
        .done     (done),
        .success  (success),
        .attempts (attempts)
    );

    // Behavioural lock: accepts 1,0,1,0,1,1; Mealy unlock; x=0 clears open/error.
    lock_state_t lk_state;
    int          flips_done    = 0;
    int          corrupt_limit = 0;
    int          inj_done      = 0;
    int          inj_limit     = 0;
    bit          ready_en      = 1'b1;
    logic        flip, inj, x_l;

    function automatic lock_state_t lock_next(input lock_state_t s, input logic xb);
        logic [5:0] c;
        int         k;
        c = LOCK_CODE;
        k = int'(s);
        case (s)
            s_open:  return xb ? s_open  : s_reset;
            s_error: return xb ? s_error : s_reset;
            s_reset: return (xb == c[5]) ? s_got1 : s_reset;
            default: return (xb == c[5-k]) ? lock_state_t'(3'(k + 1)) : s_error;
        endcase
    endfunction

    // flip corrupts the code bit at index 3 on the wire into the lock
    assign flip   = (flips_done < corrupt_limit) && (lk_state == s_got10);
    assign inj    = (inj_done < inj_limit) && (lk_state == s_open);
    assign x_l    = x ^ flip;
    assign ready  = ready_en && (lk_state == s_reset);
    assign unlock = (lk_state == s_open) && x_l;
    assign error  = (lk_state == s_error) || inj;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lk_state <= s_reset;
        end else begin
            lk_state <= lock_next(lk_state, x_l);
            if (flip) flips_done <= flips_done + 1;
            if (inj && (lock_next(lk_state, x_l) != s_open)) inj_done <= inj_done + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected x in cycle n after the edge that accepted start, nominal run.
    function automatic logic exp_nominal_x(input int n);
        logic [5:0] c;
        c = LOCK_CODE;
        if (n >= 2 && n <= 7) return c[7-n];
        if (n >= 8 && n <= 12) return 1'b1;
        return 1'b0;
    endfunction

    typedef struct {
        logic       succ;
        logic [1:0] att;
        int         lat;
        int         ones;
    } exp_t;

    exp_t sb[$];

    task automatic run_seq(input string name, input logic exp_succ, input logic [1:0] exp_att,
                           input int exp_lat, input int exp_ones, input bit chk_trace);
        exp_t e, g;
        int   n, ones;
        bit   seen;
        e.succ = exp_succ;
        e.att  = exp_att;
        e.lat  = exp_lat;
        e.ones = exp_ones;
        sb.push_back(e);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        n    = 1;
        ones = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            if (chk_trace && n < 15)
                check($sformatf("%s_x%0d", name, n), 32'(x), 32'(exp_nominal_x(n)));
            if (x) ones++;
            if (done) begin
                seen = 1'b1;
                g = sb.pop_front();
                check({name, "_success"},  32'(success),  32'(g.succ));
                check({name, "_attempts"}, 32'(attempts), 32'(g.att));
                check({name, "_busy"},     32'(busy),     32'd0);
                check({name, "_x_done"},   32'(x),        32'd0);
                check({name, "_x_ones"},   32'(ones),     32'(g.ones));
                if (g.lat > 0) check({name, "_latency"}, 32'(n), 32'(g.lat));
            end else begin
                @(negedge clock);
                n++;
            end
        end
        if (!seen) begin
            check({name, "_done_seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_x",        32'(x),        32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_success",  32'(success),  32'd0);
        check("rst_attempts", 32'(attempts), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_seq("nominal", 1'b1, 2'd1, 15, 9, 1'b1);
        check("nominal_lock_ready", 32'(ready), 32'd1);

        corrupt_limit = flips_done + 1;
        run_seq("one_err", 1'b1, 2'd2, 0, 11, 1'b0);

        corrupt_limit = flips_done + 3;
        run_seq("persist_err", 1'b0, 2'd3, 0, 6, 1'b0);

        ready_en = 1'b0;
        run_seq("rdy_timeout", 1'b0, 2'd1, 18, 0, 1'b0);
        ready_en = 1'b1;

        inj_limit = inj_done + 1;
        run_seq("unlock_err", 1'b1, 2'd2, 0, 14, 1'b0);

        // start while busy, then reset in the middle of SEND
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_start_att",  32'(attempts), 32'd1);
        check("busy_start_busy", 32'(busy),     32'd1);
        check("busy_x3",         32'(x),        32'(exp_nominal_x(3)));
        @(negedge clock);
        check("busy_x4",         32'(x),        32'(exp_nominal_x(4)));
        reset_n = 1'b0;
        #1;
        check("midrst_x",        32'(x),        32'd0);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_done",     32'(done),     32'd0);
        check("midrst_attempts", 32'(attempts), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        run_seq("post_reset", 1'b1, 2'd1, 15, 9, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
